input_encoder: RTL and testbench

INPUT_ENCODER -- requirements
Module: input_encoder

---
 rtl/input_encoder.sv | 147 ++++++++++++++
 tb/tb_input_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/input_encoder.sv
// Keypad command encoder: synchronizes 15 raw key lines, debounces press and release,
// and emits the lowest pressed key's code as a one-cycle strobe (auto-repeat for codes 7..C).
module input_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [14:0] keys,
    output logic [3:0]  outCode,
    output logic        codeStrobe,
    output logic        keyHeld
);
    localparam logic [24:0] DEB = 25'(DEBOUNCE_CYCLES);
    localparam logic [24:0] RD  = 25'(REPEAT_DELAY);
    localparam logic [24:0] RP  = 25'(REPEAT_PERIOD);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, HOLD} state_t;

    state_t      state, state_n;
    logic [14:0] sync1, svec;
    logic [14:0] lvec, lvec_n;
    logic [24:0] cnt, cnt_n;
    logic        repeated, repeated_n;
    logic        suppress, suppress_n;
    logic        zero_run, zero_run_n;
    logic [3:0]  code_n;
    logic        strobe_n, held_n;

    logic [3:0]  cur_code;
    logic        rep_ok;
    logic        zr;
    logic [24:0] target, rel_cnt, rep_cnt;

    function automatic logic [3:0] lowest_bit(input logic [14:0] v);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 14; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign cur_code = lowest_bit(lvec);
    assign rep_ok   = (cur_code >= 4'h7) && (cur_code <= 4'hC);
    assign target   = repeated ? RP : RD;
    // In HOLD the counter is either a zero-run (release) count or a repeat count.
    assign zr       = (state == HOLD) && zero_run;
    assign rel_cnt  = (zr ? cnt : 25'd0) + 25'd1;
    assign rep_cnt  = ((state == EMIT) ? 25'd0 : cnt) + 25'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            svec       <= '0;
            state      <= IDLE;
            lvec       <= '0;
            cnt        <= '0;
            repeated   <= 1'b0;
            suppress   <= 1'b0;
            zero_run   <= 1'b0;
            outCode    <= 4'hF;
            codeStrobe <= 1'b0;
            keyHeld    <= 1'b0;
        end else begin
            sync1      <= keys;
            svec       <= sync1;
            state      <= state_n;
            lvec       <= lvec_n;
            cnt        <= cnt_n;
            repeated   <= repeated_n;
            suppress   <= suppress_n;
            zero_run   <= zero_run_n;
            outCode    <= code_n;
            codeStrobe <= strobe_n;
            keyHeld    <= held_n;
        end
    end

    always_comb begin
        state_n    = state;
        lvec_n     = lvec;
        cnt_n      = cnt;
        repeated_n = repeated;
        suppress_n = suppress;
        zero_run_n = zero_run;
        case (state)
            IDLE: begin
                cnt_n      = '0;
                suppress_n = 1'b0;
                zero_run_n = 1'b0;
                if (svec != '0) begin
                    lvec_n     = svec;
                    cnt_n      = 25'd1;
                    repeated_n = 1'b0;
                    state_n    = (DEB == 25'd1) ? EMIT : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (svec != lvec) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 25'd1;
                    if (cnt + 25'd1 == DEB) state_n = EMIT;
                end
            end
            EMIT, HOLD: begin
                state_n = HOLD;
                if (svec == '0) begin
                    zero_run_n = 1'b1;
                    cnt_n      = rel_cnt;
                    if (rel_cnt == DEB) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    zero_run_n = 1'b0;
                    // A changed vector or a short dropout ends repeating until a full release.
                    suppress_n = suppress | (svec != lvec) | zr;
                    if (!suppress_n && rep_ok) begin
                        cnt_n = rep_cnt;
                        if (rep_cnt == target) begin
                            state_n    = EMIT;
                            repeated_n = 1'b1;
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        code_n   = 4'hF;
        strobe_n = 1'b0;
        held_n   = (state_n == EMIT) || (state_n == HOLD);
        if (state_n == EMIT) begin
            code_n   = lowest_bit(lvec_n);
            strobe_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_input_encoder.sv
// Scoreboard bench for input_encoder with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_input_encoder;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] keys  = '0;
    logic [3:0]  outCode;
    logic        codeStrobe;
    logic        keyHeld;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    input_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .keys      (keys),
        .outCode   (outCode),
        .codeStrobe(codeStrobe),
        .keyHeld   (keyHeld)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the expected queue at the right cycle.
    always @(negedge clock) begin
        exp_t e;
        if (codeStrobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: code %h at cycle %0d, expected no pulse", outCode, cyc);
            end else begin
                e = exp_q.pop_front();
                if (outCode !== e.code || cyc != e.at) begin
                    errors++;
                    $display("FAIL pulse: got code %h at cycle %0d, expected code %h at cycle %0d",
                             outCode, cyc, e.code, e.at);
                end
            end
        end else begin
            checks++;
            if (outCode !== 4'hF) begin
                errors++;
                $display("FAIL idle_code: outCode %h at cycle %0d without strobe, expected F", outCode, cyc);
            end
            if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: code %h expected at cycle %0d, absent at cycle %0d",
                         exp_q[0].code, exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_pulse(input logic [3:0] c, input int at);
        exp_t e;
        e.code = c;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check_held(input string name, input logic want);
        checks++;
        if (keyHeld !== want) begin
            errors++;
            $display("FAIL %s: keyHeld %b at cycle %0d, expected %b", name, keyHeld, cyc, want);
        end
    endtask

    task automatic check_outs(input string name);
        checks++;
        if (outCode !== 4'hF || codeStrobe !== 1'b0 || keyHeld !== 1'b0) begin
            errors++;
            $display("FAIL %s: outCode %h strobe %b held %b, expected F 0 0",
                     name, outCode, codeStrobe, keyHeld);
        end
    endtask

    // Release keys and check the fixed release latency on keyHeld.
    task automatic release_and_check(input string name);
        keys = '0;
        tick(DEB + 1);
        check_held({name, "_before_release"}, 1'b1);
        tick(1);
        check_held({name, "_after_release"}, 1'b0);
        tick(10);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  dropped;

        #2 reset = 1'b1;
        tick(2);
        check_outs("reset_state");
        reset = 1'b0;
        tick(1);

        // Idle: nothing may appear.
        tick(1000);
        check_outs("idle_1000");

        // Single non-repeatable press held 40 clocks.
        keys = 15'h0004;
        n = cyc;
        expect_pulse(4'h2, n + DEB + 2);
        tick(DEB + 2);
        check_held("press_emit", 1'b1);
        tick(40 - (DEB + 2));
        release_and_check("press");

        // Bounce on key 9, then a stable hold with repeats.
        for (int i = 0; i < 5; i++) begin
            keys = 15'h0200;
            tick(2);
            keys = '0;
            tick(2);
        end
        keys = 15'h0200;
        n = cyc;
        expect_pulse(4'h9, n + 6);
        expect_pulse(4'h9, n + 6 + RD);
        expect_pulse(4'h9, n + 6 + RD + RP);
        expect_pulse(4'h9, n + 6 + RD + 2 * RP);
        tick(46);
        release_and_check("repeat");

        // Two keys together: lowest wins; partial release emits nothing.
        keys = 15'h0810;
        expect_pulse(4'h4, cyc + 6);
        tick(30);
        check_held("priority_hold", 1'b1);
        keys = 15'h0800;
        tick(30);
        check_held("partial_release", 1'b1);
        release_and_check("priority");

        // Two-clock dropout on key E must not re-emit or drop keyHeld.
        keys = 15'h4000;
        expect_pulse(4'hE, cyc + 6);
        tick(20);
        dropped = 1'b0;
        keys = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 2) keys = 15'h4000;
            tick(1);
            if (keyHeld !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin
            errors++;
            $display("FAIL glitch_held: keyHeld fell during dropout, expected to stay 1");
        end
        release_and_check("glitch");

        // Reset during debounce of key 0; key still held afterwards.
        keys = 15'h0001;
        tick(4);
        reset = 1'b1;
        #1;
        check_outs("reset_mid_debounce");
        tick(3);
        reset = 1'b0;
        expect_pulse(4'h0, cyc + 6);
        tick(15);
        check_held("after_reset_hold", 1'b1);
        release_and_check("after_reset");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected pulses never observed, expected 0", exp_q.size());
        end
        check_outs("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
